// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Program loader placed in front of the instruction memory. It accepts
// symbolic instruction fields over a valid/ready stream, encodes each bundle
// into a 9-bit machine word for the 4-bit-opcode control decoder, and writes
// the words to consecutive instruction-memory addresses starting at 0.
// When the program is complete, load_done is raised to release the core.
//
// Optional feature macro: ENC_FIELD_CHECK_EN
//   defined   : reserved opcode 1110, I-type imm > 7 and R-type imm != 0 are
//               rejected (no write, err[0] set).
//   undefined : no checks; 1110 encodes like NOP and I-type immediates are
//               truncated to 3 bits. err[0] never sets.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   start               : one-cycle pulse, (re)starts a load at address 0
//   in_valid / in_ready : field bundle stream
//   in_op/rd/rs/imm     : symbolic instruction fields
//   in_last             : bundle is the final instruction of the program
//   im_we/addr/wdata    : instruction-memory write port (registered)
//   load_done           : high while the FSM is in DONE
//   err                 : sticky, bit0 = illegal field, bit1 = overflow
//   word_count          : words written in the current load
//   fsm_state           : current FSM state (0 IDLE, 1 LOAD, 2 DONE)
//
// Handshake: a bundle transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is registered and does not depend on in_valid; the
// source must hold the bundle stable until it transfers.
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int IW = 9,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [1:0]    in_rd,
    input  logic [1:0]    in_rs,
    input  logic [4:0]    in_imm,
    input  logic          in_last,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [IW-1:0] im_wdata,
    output logic          load_done,
    output logic [1:0]    err,
    output logic [AW:0]   word_count,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] addr;      // next address to write
    logic [IW-1:0] enc;
    logic          illegal;
    logic          hs;

    assign fsm_state = state;
    assign hs        = in_valid & in_ready;

    // Field encoder. The word layout is fixed at 9 bits.
    always_comb begin
        enc      = '0;
        enc[8:5] = in_op;
        illegal  = 1'b0;
        case (in_op)
            // R-type: ADD MOV OR XOR AND CMP
            4'h0, 4'h3, 4'h4, 4'h5, 4'h6, 4'hD: begin
                enc[4:3] = in_rd;
                enc[2:1] = in_rs;
`ifdef ENC_FIELD_CHECK_EN
                illegal  = (in_imm != 5'd0);
`endif
            end
            // I-type: SLL SLR ADDi MOVi SW LW
            4'h1, 4'h2, 4'h7, 4'hA, 4'hB, 4'hC: begin
                enc[4:3] = in_rd;
                enc[2:0] = in_imm[2:0];
`ifdef ENC_FIELD_CHECK_EN
                illegal  = (in_imm[4:3] != 2'b00);
`endif
            end
            // B-type: BNE BEQ
            4'h8, 4'h9: begin
                enc[4:0] = in_imm;
            end
            // Reserved opcode; without checks it encodes like NOP
            4'hE: begin
`ifdef ENC_FIELD_CHECK_EN
                illegal = 1'b1;
`endif
            end
            // NOP: operand field stays zero
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            in_ready   <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            load_done  <= 1'b0;
            err        <= 2'b00;
            word_count <= '0;
        end else begin
            im_we <= 1'b0;
            if (start) begin
                // Restart from any state; a coincident bundle is discarded.
                // in_ready stays low for one cycle after start.
                state      <= S_LOAD;
                addr       <= '0;
                in_ready   <= 1'b0;
                load_done  <= 1'b0;
                err        <= 2'b00;
                word_count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        in_ready <= 1'b0;
                    end
                    S_LOAD: begin
                        in_ready <= 1'b1;
                        if (hs) begin
                            if (illegal) begin
                                err[0] <= 1'b1;
                                if (in_last) begin
                                    state     <= S_DONE;
                                    in_ready  <= 1'b0;
                                    load_done <= 1'b1;
                                end
                            end else begin
                                im_we      <= 1'b1;
                                im_addr    <= addr;
                                im_wdata   <= enc;
                                word_count <= word_count + (AW+1)'(1);
                                if (in_last) begin
                                    state     <= S_DONE;
                                    in_ready  <= 1'b0;
                                    load_done <= 1'b1;
                                end else if (addr == '1) begin
                                    // Last address used without in_last:
                                    // terminate rather than wrap.
                                    err[1]    <= 1'b1;
                                    state     <= S_DONE;
                                    in_ready  <= 1'b0;
                                    load_done <= 1'b1;
                                end else begin
                                    addr <= addr + AW'(1);
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        in_ready  <= 1'b0;
                        load_done <= 1'b1;
                    end
                    default: begin
                        state    <= S_IDLE;
                        in_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
